memory_access_stage: RTL and testbench

//  Pipelined MEM stage: consumes EX/MEM register outputs and runs loads/stores on a req/ready data bus.

---
 rtl/riscv_pkg.sv | 12 +
 rtl/load_store_align.sv | 32 +++
 rtl/memory_access_stage.sv | 119 +++++++++++
 tb/tb_memory_access_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared load/store size codes and MEM-stage FSM states
// LS_* values are the funct3 encodings seen on LS_modeM.
// Bit 2 marks an unsigned (zero-extending) load.
// Bits 1:0 give the access size.
package riscv_pkg;
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  typedef enum logic {IDLE, REQ} mem_state_t;
endpackage

// File: rtl/load_store_align.sv
// load_store_align: combinational byte-lane steering for sub-word loads and stores
// addr       in  2   low address bits selecting the byte lane
// ls_mode    in  3   funct3 size/sign code
// wd         in  32  store data (rs2)
// rdata      in  32  word returned by the bus
// wstrb      out 4   byte enables for a store
// wdata      out 32  lane-replicated store data
// load       out 32  aligned, sign/zero-extended load result
// misaligned out 1   halfword on an odd address, or word not on a 4-byte boundary
module load_store_align import riscv_pkg::*; (
  input  logic [1:0]  addr,
  input  logic [2:0]  ls_mode,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load,
  output logic        misaligned
);
  logic is_b, is_h, uns;
  logic [31:0] sh;
  always_comb begin
    is_b = ls_mode == LS_B || ls_mode == LS_BU;
    is_h = ls_mode == LS_H || ls_mode == LS_HU;
    uns = ls_mode == LS_BU || ls_mode == LS_HU;
    sh = rdata >> {addr, 3'b000};
    misaligned = (is_h && addr[0]) || (ls_mode == LS_W && addr != 2'b00);
    wstrb = is_b ? 4'b0001 << addr : is_h ? 4'b0011 << addr : 4'b1111;
    wdata = is_b ? {4{wd[7:0]}} : is_h ? {2{wd[15:0]}} : wd;
    load = is_b ? {{24{!uns && sh[7]}}, sh[7:0]} : is_h ? {{16{!uns && sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: pipelined MEM stage driving a req/ready data bus and the MEM/WB register
// clk, rst                      clock; asynchronous active-low reset
// ALUResultM..LS_modeM          EX/MEM register contents
// mem_req/we/addr/wdata/wstrb   bus request, held from latched copies while in REQ
// mem_rdata, mem_ready          bus response, only honoured in REQ
// StallM                        combinational hold for the upstream pipeline
// *W                            MEM/WB register; FaultW pulses on misalignment or bus timeout
module memory_access_stage import riscv_pkg::*; #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  input  logic                  MemWriteM,
  input  logic                  MemReadM,
  input  logic [4:0]            RdM,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            LS_modeM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ALUResultW,
  output logic [DATA_WIDTH-1:0] ReadDataW,
  output logic [DATA_WIDTH-1:0] PCPlus4W,
  output logic [4:0]            RdW,
  output logic                  RegWriteW,
  output logic [1:0]            ResultSrcW,
  output logic                  FaultW
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  mem_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic access, mis, to, go, fault_n, bubble;
  logic [DATA_WIDTH-1:0] lat_addr;
  logic [2:0] lat_mode;
  logic [1:0] a_sel;
  logic [2:0] m_sel;
  logic [3:0] al_wstrb;
  logic [DATA_WIDTH-1:0] al_wdata, al_load;
  // In REQ the aligner works on the latched address/mode so the load result
  // matches the request that is actually on the bus.
  assign a_sel = state == REQ ? lat_addr[1:0] : ALUResultM[1:0];
  assign m_sel = state == REQ ? lat_mode : LS_modeM;
  load_store_align u_align (
    .addr(a_sel),
    .ls_mode(m_sel),
    .wd(WriteDataM),
    .rdata(mem_rdata),
    .wstrb(al_wstrb),
    .wdata(al_wdata),
    .load(al_load),
    .misaligned(mis)
  );
  assign access = MemReadM | MemWriteM;
  assign go = state == IDLE && access && !mis;
  assign to = state == REQ && cnt == CW'(TIMEOUT_CYCLES - 1) && !mem_ready;
  assign mem_addr = {lat_addr[DATA_WIDTH-1:2], 2'b00};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == REQ && state_n == REQ) ? cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    state_n = state == IDLE ? (go ? REQ : IDLE) : ((mem_ready || to) ? IDLE : REQ);
  end
  always_comb begin
    mem_req = state == REQ;
    StallM = access && !mis && !(state == REQ && (mem_ready || to));
    fault_n = (state == IDLE && access && mis) || to;
    bubble = StallM || fault_n;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr <= '0;
      lat_mode <= '0;
      mem_we <= 1'b0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (go) begin
      lat_addr <= ALUResultM;
      lat_mode <= LS_modeM;
      mem_we <= MemWriteM;
      mem_wdata <= al_wdata;
      mem_wstrb <= al_wstrb;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ALUResultW <= '0;
      ReadDataW <= '0;
      PCPlus4W <= '0;
      RdW <= '0;
      RegWriteW <= 1'b0;
      ResultSrcW <= '0;
      FaultW <= 1'b0;
    end else begin
      ALUResultW <= bubble ? '0 : ALUResultM;
      ReadDataW <= (!bubble && state == REQ && !mem_we) ? al_load : '0;
      PCPlus4W <= bubble ? '0 : PCPlus4M;
      RdW <= bubble ? '0 : RdM;
      RegWriteW <= !bubble && RegWriteM && !MemWriteM;
      ResultSrcW <= bubble ? '0 : ResultSrcM;
      FaultW <= fault_n;
    end
  end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: scoreboard bench with a transaction-level model of the MEM stage
module tb_memory_access_stage;
  localparam int TO = 16;
  logic clk = 0, rst = 0;
  logic [31:0] ALUResultM = 0, WriteDataM = 0, PCPlus4M = 0, mem_rdata = 0;
  logic MemWriteM = 0, MemReadM = 0, RegWriteM = 0, mem_ready = 0;
  logic [4:0] RdM = 0;
  logic [1:0] ResultSrcM = 0;
  logic [2:0] LS_modeM = 0;
  logic mem_req, mem_we, StallM, RegWriteW, FaultW;
  logic [31:0] mem_addr, mem_wdata, ALUResultW, ReadDataW, PCPlus4W;
  logic [3:0] mem_wstrb;
  logic [4:0] RdW;
  logic [1:0] ResultSrcW;
  memory_access_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM), .RdM(RdM), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .LS_modeM(LS_modeM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .StallM(StallM), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .FaultW(FaultW)
  );
  always #5 clk = ~clk;
  typedef struct {
    int cyc;
    logic [31:0] alu, rdat, pc4, addr, wdata;
    logic [4:0] rd;
    logic [1:0] rs;
    logic [3:0] wstrb;
    logic rw, flt, rdv, stall, req, we;
  } exp_t;
  exp_t q[$];
  exp_t w_prev;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask
  // Monitor: each cycle that has an expectation, compare the visible MEM/WB
  // register and the current-cycle stall/bus signals.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("ALUResultW", ALUResultW, e.alu);
      chk("PCPlus4W", PCPlus4W, e.pc4);
      chk("RdW", 32'(RdW), 32'(e.rd));
      chk("RegWriteW", 32'(RegWriteW), 32'(e.rw));
      chk("ResultSrcW", 32'(ResultSrcW), 32'(e.rs));
      chk("FaultW", 32'(FaultW), 32'(e.flt));
      if (e.rdv) chk("ReadDataW", ReadDataW, e.rdat);
      chk("StallM", 32'(StallM), 32'(e.stall));
      chk("mem_req", 32'(mem_req), 32'(e.req));
      if (e.req) begin
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", 32'(mem_we), 32'(e.we));
        if (e.we) begin
          chk("mem_wdata", mem_wdata, e.wdata);
          chk("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
        end
      end
    end
  end
  function automatic int msize(input logic [2:0] mode);
    return (mode == 3'b000 || mode == 3'b100) ? 1 : (mode == 3'b001 || mode == 3'b101) ? 2 : 4;
  endfunction
  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [31:0] w, input logic [2:0] mode);
    int sz = msize(mode);
    logic [31:0] mask = sz == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    logic [31:0] v = (w >> (8 * (a % 4))) & mask;
    if (!mode[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction
  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int sz);
    return sz == 1 ? {24'd0, wd[7:0]} * 32'h0101_0101 : sz == 2 ? {16'd0, wd[15:0]} * 32'h0001_0001 : wd;
  endfunction
  function automatic logic [3:0] m_wstrb(input logic [31:0] a, input int sz);
    return sz == 4 ? 4'hF : 4'(((1 << sz) - 1) << (a % 4));
  endfunction
  function automatic exp_t bub(input logic f);
    exp_t b = '{default: 0};
    b.flt = f;
    b.rdv = 1'b1;
    return b;
  endfunction
  // One clock of stimulus: schedule what the monitor must see this cycle, then advance.
  task automatic step(input logic stall, input logic req, input logic ready, input logic [31:0] rdata,
                      input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input logic we);
    exp_t e = w_prev;
    e.cyc = cyc;
    e.stall = stall;
    e.req = req;
    e.addr = a;
    e.wdata = wd;
    e.wstrb = ws;
    e.we = we;
    mem_ready = ready;
    mem_rdata = rdata;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  // lat = REQ cycle on which mem_ready is given (1..TO), 0 = never (timeout).
  task automatic run_op(input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                        input logic mr, input logic mw, input logic [4:0] rd, input logic rw,
                        input logic [1:0] rs, input logic [2:0] mode, input int lat, input logic [31:0] rword);
    int sz = msize(mode);
    logic [31:0] ea = alu & ~32'd3;
    logic [31:0] ew = m_wdata(wd, sz);
    logic [3:0] es = m_wstrb(alu, sz);
    logic done, tmo;
    exp_t e;
    ALUResultM = alu; WriteDataM = wd; PCPlus4M = pc4; MemReadM = mr; MemWriteM = mw;
    RdM = rd; RegWriteM = rw; ResultSrcM = rs; LS_modeM = mode;
    if (!(mr || mw)) begin
      step(0, 0, 1'($urandom % 2), $urandom, 0, 0, 0, 0);
      e = bub(0);
      e.alu = alu; e.pc4 = pc4; e.rd = rd; e.rw = rw; e.rs = rs; e.rdv = 0;
      w_prev = e;
    end else if (alu % sz != 0) begin
      step(0, 0, 1'($urandom % 2), $urandom, 0, 0, 0, 0);
      w_prev = bub(1);
    end else begin
      step(1, 0, 1'($urandom % 2), $urandom, 0, 0, 0, 0);
      w_prev = bub(0);
      for (int k = 1; k <= TO; k++) begin
        done = k == lat;
        tmo = lat == 0 && k == TO;
        step(!(done || tmo), 1, done, done ? rword : $urandom, ea, ew, es, mw);
        if (done) begin
          e = bub(0);
          e.alu = alu; e.pc4 = pc4; e.rd = rd; e.rw = rw && !mw; e.rs = rs;
          e.rdv = !mw;
          e.rdat = mw ? 32'd0 : m_load(alu, rword, mode);
          w_prev = e;
          break;
        end
        w_prev = bub(tmo);
        if (tmo) break;
      end
    end
  endtask
  initial begin
    logic [2:0] modes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] m;
    logic [31:0] a;
    int kind;
    w_prev = bub(0);
    #1;
    chk("reset mem_req", 32'(mem_req), 0);
    chk("reset ALUResultW", ALUResultW, 0);
    chk("reset RegWriteW", 32'(RegWriteW), 0);
    chk("reset FaultW", 32'(FaultW), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;
    run_op(32'h1234, 0, 32'h10, 0, 0, 5, 1, 0, 3'b010, 0, 0);
    run_op(32'h103, 32'hAABBCCDD, 32'h14, 0, 1, 7, 0, 0, 3'b000, 1, 0);
    run_op(32'h202, 0, 32'h18, 1, 0, 9, 1, 1, 3'b000, 3, 32'h0080FF00);
    run_op(32'h202, 0, 32'h1C, 1, 0, 10, 1, 1, 3'b100, 3, 32'h0080FF00);
    run_op(32'h006, 0, 32'h20, 1, 0, 11, 1, 1, 3'b010, 1, 0);
    run_op(32'h040, 32'h55667788, 32'h24, 0, 1, 3, 1, 0, 3'b010, 0, 0);
    run_op(32'h5678, 0, 32'h28, 0, 0, 12, 1, 2, 3'b000, 0, 0);
    // Reset asserted in the middle of a REQ phase.
    ALUResultM = 32'h80; MemReadM = 1; MemWriteM = 0; LS_modeM = 3'b010; RdM = 4; RegWriteM = 1;
    step(1, 0, 0, $urandom, 0, 0, 0, 0);
    w_prev = bub(0);
    step(1, 1, 0, $urandom, 32'h80, 0, 0, 0);
    #2 rst = 0;
    #1;
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst ALUResultW", ALUResultW, 0);
    chk("rst ReadDataW", ReadDataW, 0);
    chk("rst RdW", 32'(RdW), 0);
    chk("rst RegWriteW", 32'(RegWriteW), 0);
    chk("rst FaultW", 32'(FaultW), 0);
    MemReadM = 0;
    @(posedge clk); #1;
    rst = 1;
    w_prev = bub(0);
    run_op(32'h84, 0, 32'h30, 1, 0, 6, 1, 1, 3'b010, 2, 32'hCAFEF00D);
    for (int i = 0; i < 400; i++) begin
      kind = $urandom % 3;
      m = kind == 2 ? modes[$urandom % 3] : modes[$urandom % 5];
      a = $urandom;
      if ($urandom % 3 != 0) a = a & ~32'(msize(m) - 1);
      run_op(a, $urandom, $urandom, kind == 1, kind == 2, 5'($urandom), 1'($urandom % 2),
             2'($urandom), m, ($urandom % 16 == 0) ? 0 : 1 + $urandom % 4, $urandom);
    end
    run_op(32'h9999, 0, 32'h40, 0, 0, 1, 1, 0, 3'b010, 0, 0);
    run_op(32'h0, 0, 32'h0, 0, 0, 0, 0, 0, 3'b010, 0, 0);
    @(posedge clk); #1;
    chk("queue drained", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
